timer_multi_core: RTL
=====================

Name: timer_multi_core

Overview:
Multi-channel, parametrised successor to the single free-running sample-and-hold timer core. Provides N_CH independent counters. Each channel has:
- a prescaler;
- a compare value;
- free-run, periodic auto-reload and one-shot modes;
- a sample/hold snapshot register;
- a sticky interrupt flag with acknowledge.

It sits behind the timer's software-register block, which drives the control inputs and reads the value/status outputs.

Parameters:
CNT_W, 64, counter, compare and snapshot width per channel
N_CH, 4, number of independent channels (1..16)
PRESC_W, 16, prescaler reload width

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
ch_enable  input  N_CH  per-channel run enable (level)
ch_mode  input  2*N_CH  per-channel mode: 0 free-run, 1 periodic, 2 one-shot, 3 treated as free-run
ch_prescale  input  PRESC_W*N_CH  tick every (prescale+1) clk cycles
ch_compare  input  CNT_W*N_CH  match value
ch_clear  input  N_CH  one-cycle pulse: zero counter and prescaler, return to IDLE
ch_sample  input  N_CH  one-cycle pulse: snapshot counter into ch_value
irq_ack  input  N_CH  one-cycle pulse: clear the sticky irq bit
ch_value  output  CNT_W*N_CH  snapshot register per channel
ch_match  output  N_CH  one-cycle registered match pulse
ch_running  output  N_CH  1 while the channel is in RUN
irq  output  N_CH  sticky interrupt per channel

Behaviour:
- Reset (rst_n=0, async): all counters, prescalers, ch_value, ch_match and irq are 0; all channels in IDLE; ch_running=0.

Per-channel FSM (IDLE, RUN, DONE):
- IDLE: enable=1 -> RUN.
- RUN: enable=0 -> IDLE, holding counter and prescaler (pause, no loss). One-shot match -> DONE.
- DONE: counter holds the compare value. Exits only via clear (-> IDLE); enable is ignored.
- ch_running = (state==RUN).

Prescaler and tick:
- In RUN, the prescaler increments each cycle.
- tick = (presc==ch_prescale); on tick, presc <= 0. prescale=0 gives a tick every cycle.
- Counter changes only on tick.

Counter actions on tick (hit = counter==compare):
- Free-run: counter+1, wrapping 2^CNT_W-1 -> 0. hit still pulses ch_match, and counting continues.
- Periodic: on hit counter <= 0, else +1. Period = (compare+1)*(prescale+1) clk cycles. compare=0 gives a match on every tick with the counter held at 0.
- One-shot: on hit, counter holds and the FSM goes to DONE, else +1.

Match and interrupt:
- ch_match goes high the cycle after the hit tick, for exactly 1 cycle.
- irq sets in the same cycle as ch_match.
- irq stays set until irq_ack. If set and ack coincide, set wins.

Sample:
- ch_value <= counter (the pre-update value of that cycle) on ch_sample; otherwise holds.
- Sample with clear in the same cycle captures the pre-clear value.

Clear:
- Priority: clear > tick.
- Counter and prescaler go to 0; ch_match is suppressed that cycle; irq is unaffected.
- Next state is IDLE. If enable is still 1, the FSM re-enters RUN the following cycle.

Input changes:
- Mode, compare and prescale may change at any time and take effect on the next tick. No shadow registers.
- Compare lowered below the counter in periodic mode: the counter runs to wrap, then matches on the next pass.

Channels share nothing except clk and rst_n.

Decomposition:
- Package timer_multi_pkg holds:
  - mode constants MODE_FREE=0, MODE_PERIODIC=1, MODE_ONESHOT=2;
  - FSM state encoding ST_IDLE, ST_RUN, ST_DONE (2 bits).
- Sub-module timer_channel implements one channel (FSM, prescaler, counter, snapshot, match, irq). It is instantiated N_CH times by a generate loop in timer_multi_core, which only slices the flattened buses.

Test Plan:
- Reset, then ch0 free-run, prescale=0, enable 10 cycles, sample -> ch_value=10 (±1 per documented sample timing). All irq=0 while compare is max.
- ch1 periodic, compare=3, prescale=1 -> ch_match every 8 clk. Counter sequence 0,1,2,3,0. irq stays 1 until irq_ack. Ack coinciding with a match leaves irq=1.
- ch2 one-shot, compare=5, prescale=0 -> single ch_match 1 cycle after the counter reaches 5; ch_running falls; the counter holds 5 for 20 cycles; clear -> counter 0, FSM re-enters RUN.
- Free-run wrap with CNT_W=8 build: count from 254 -> 255, 0, 1; compare=0 produces a match at the wrap.
- Pause: deassert enable at counter=7 mid-prescale for 5 cycles, reassert -> resumes at 7 with the prescaler phase preserved. Simultaneous clear+sample -> ch_value holds the pre-clear count.
- Async reset asserted mid-count on all channels, off-edge -> outputs 0 immediately; after release all channels are IDLE until enable.

Source files
------------

// File: rtl/timer_multi_core_pkg.sv
// Shared definitions for the multi-channel timer core: mode codes,
// per-channel FSM state encoding and the mode decode helper.
package timer_multi_pkg;

    // Channel operating modes as presented on ch_mode
    localparam logic [1:0] MODE_FREE     = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    // Code 3 is reserved and behaves exactly like free-run
    function automatic logic [1:0] decode_mode(input logic [1:0] raw);
        return (raw == 2'd3) ? MODE_FREE : raw;
    endfunction

endpackage

// File: rtl/timer_multi_core_if.sv
// Control/status bus between the timer register block (master) and the
// multi-channel timer core (slave). All per-channel fields are flattened,
// channel 0 in the least significant slice.
interface timer_multi_core_if #(
    parameter int CNT_W   = 64,
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16
);
    logic [N_CH-1:0]         ch_enable;
    logic [2*N_CH-1:0]       ch_mode;
    logic [PRESC_W*N_CH-1:0] ch_prescale;
    logic [CNT_W*N_CH-1:0]   ch_compare;
    logic [N_CH-1:0]         ch_clear;
    logic [N_CH-1:0]         ch_sample;
    logic [N_CH-1:0]         irq_ack;
    logic [CNT_W*N_CH-1:0]   ch_value;
    logic [N_CH-1:0]         ch_match;
    logic [N_CH-1:0]         ch_running;
    logic [N_CH-1:0]         irq;

    // Register block side: drives controls, reads status
    modport master (
        output ch_enable, ch_mode, ch_prescale, ch_compare,
        output ch_clear, ch_sample, irq_ack,
        input  ch_value, ch_match, ch_running, irq
    );

    // Timer core side
    modport slave (
        input  ch_enable, ch_mode, ch_prescale, ch_compare,
        input  ch_clear, ch_sample, irq_ack,
        output ch_value, ch_match, ch_running, irq
    );

endinterface

// File: rtl/timer_multi_core_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, prescaler, counter with
// free-run / periodic / one-shot behaviour, sample-and-hold snapshot,
// registered match pulse and sticky interrupt.
module timer_channel
    import timer_multi_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [CNT_W-1:0]   compare,
    input  logic               clear,
    input  logic               sample,
    input  logic               irq_ack,
    output logic [CNT_W-1:0]   value,
    output logic               match,
    output logic               running,
    output logic               irq
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    ch_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   value_q;
    logic               match_q, match_d;
    logic               irq_q;
    logic               hit;

    // Compare is live: a new value takes effect on the very next tick
    assign hit = (cnt_q == compare);

    // Next-state, prescaler and counter update; clear outranks everything
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Pause: counter and prescaler phase are kept
                        state_d = ST_IDLE;
                    end else if (presc_q != prescale) begin
                        presc_d = presc_q + PRESC_ONE;
                    end else begin
                        // Tick
                        presc_d = '0;
                        match_d = hit;
                        case (decode_mode(mode))
                            MODE_PERIODIC: cnt_d = hit ? '0 : cnt_q + CNT_ONE;
                            MODE_ONESHOT: begin
                                if (hit) state_d = ST_DONE;
                                else     cnt_d   = cnt_q + CNT_ONE;
                            end
                            default:       cnt_d = cnt_q + CNT_ONE;
                        endcase
                    end
                end
                ST_DONE: begin
                    // Parked on the compare value until cleared
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Prescaler, counter and registered match pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    // Sticky interrupt: a new match wins over a coincident acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       irq_q <= 1'b0;
        else if (match_d) irq_q <= 1'b1;
        else if (irq_ack) irq_q <= 1'b0;
    end

    // Snapshot of the counter as it stood before this edge's update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      value_q <= '0;
        else if (sample) value_q <= cnt_q;
    end

    assign value   = value_q;
    assign match   = match_q;
    assign running = (state_q == ST_RUN);
    assign irq     = irq_q;

endmodule

// File: rtl/timer_multi_core.sv
// Multi-channel timer core: N_CH independent timer_channel instances,
// each fed from its own slice of the flattened control/status bus.
module timer_multi_core
    import timer_multi_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_multi_core_if.slave bus
);

    logic [CNT_W*N_CH-1:0] value_flat;
    logic [N_CH-1:0]       match_vec;
    logic [N_CH-1:0]       running_vec;
    logic [N_CH-1:0]       irq_vec;

    // One channel per slice; channels share nothing but clk and rst_n
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (bus.ch_enable[g]),
            .mode     (bus.ch_mode[2*g +: 2]),
            .prescale (bus.ch_prescale[PRESC_W*g +: PRESC_W]),
            .compare  (bus.ch_compare[CNT_W*g +: CNT_W]),
            .clear    (bus.ch_clear[g]),
            .sample   (bus.ch_sample[g]),
            .irq_ack  (bus.irq_ack[g]),
            .value    (value_flat[CNT_W*g +: CNT_W]),
            .match    (match_vec[g]),
            .running  (running_vec[g]),
            .irq      (irq_vec[g])
        );
    end

    assign bus.ch_value   = value_flat;
    assign bus.ch_match   = match_vec;
    assign bus.ch_running = running_vec;
    assign bus.irq        = irq_vec;

endmodule
